// File: rtl/bcd2bin.sv
// bcd2bin: sequential two-digit BCD to binary converter (reverse double-dabble)
// with non-BCD and range error flagging; fixed 8-clock latency.
module bcd2bin #(
    parameter int BIN_WIDTH = 6,
    parameter int MAX_VALUE = 59
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           high_bcd,
    input  logic [3:0]           low_bcd,
    output logic [BIN_WIDTH-1:0] binary,
    output logic                 valid,
    output logic                 busy,
    output logic                 error
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [6:0] MAX = 7'(MAX_VALUE);
    state_t     state;
    logic [7:0] sr, s, s_fix;
    logic [6:0] acc;
    logic [2:0] cnt;
    logic       bad, err;
    // after each right shift a tens nibble bit entering the units nibble is worth 5, not 8
    always_comb begin
        s     = sr >> 1;
        s_fix = {s[7:4] >= 4'd8 ? s[7:4] - 4'd3 : s[7:4],
                 s[3:0] >= 4'd8 ? s[3:0] - 4'd3 : s[3:0]};
        err   = bad | (acc > MAX);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            bad    <= 1'b0;
            binary <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            error  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sr    <= {high_bcd, low_bcd};
                    acc   <= '0;
                    cnt   <= '0;
                    bad   <= (high_bcd > 4'd9) | (low_bcd > 4'd9);
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    acc   <= {sr[0], acc[6:1]};
                    sr    <= s_fix;
                    cnt   <= cnt + 3'd1;
                    state <= cnt == 3'd6 ? DONE : SHIFT;
                end
                DONE: begin
                    error  <= err;
                    binary <= err ? '0 : acc[BIN_WIDTH-1:0];
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
